// File: rtl/spi_bist_if.sv
// Control and observation bundle of the SPI loopback self-test.
// The design side uses the slave modport; the driver/observer side uses master.
interface spi_bist_if;
    logic       master_writeread;
    logic [7:0] MOSI_user_input;
    logic [7:0] MISO_user_input;
    logic       select;
    logic       CS;
    logic       S_clk;
    logic [3:0] counter;
    logic       MOSI_res;
    logic       MISO_res;
    logic [7:0] BIST_output;

    modport slave (
        input  master_writeread, MOSI_user_input, MISO_user_input, select,
        output CS, S_clk, counter, MOSI_res, MISO_res, BIST_output
    );

    modport master (
        output master_writeread, MOSI_user_input, MISO_user_input, select,
        input  CS, S_clk, counter, MOSI_res, MISO_res, BIST_output
    );
endinterface

// File: rtl/spi_bist.sv
// SPI loopback self-test: an internal mode-0 master and slave exchange one byte
// per transfer and compare what each received with what the other sent.
//
// state | meaning
// IDLE  | CS high, S_clk low; wait for master_writeread
// LOAD  | latch transmit bytes, drop CS, present both MSBs
// SHIFT | 16 cycles: S_clk rises (sample) and falls (count, next bit)
// CHECK | raise CS, compare bytes, update status and transfer count
module spi_bist #(
    parameter logic [7:0] DEF_MOSI = 8'hA5,
    parameter logic [7:0] DEF_MISO = 8'h5A
) (
    input logic        clk,
    input logic        reset,
    spi_bist_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        CHECK = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] tx_m_q, tx_m_d;
    logic [7:0] tx_s_q, tx_s_d;
    logic [7:0] rx_m_q, rx_m_d;
    logic [7:0] rx_s_q, rx_s_d;
    logic       cs_q, cs_d;
    logic       sclk_q, sclk_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mosi_q, mosi_d;
    logic       miso_q, miso_d;
    logic [7:0] bist_q, bist_d;

    logic [2:0] nxt_bit;
    logic       mosi_fail;
    logic       miso_fail;
    logic [3:0] xfer_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tx_m_q  <= 8'h00;
            tx_s_q  <= 8'h00;
            rx_m_q  <= 8'h00;
            rx_s_q  <= 8'h00;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            cnt_q   <= 4'd0;
            mosi_q  <= 1'b0;
            miso_q  <= 1'b0;
            bist_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            tx_m_q  <= tx_m_d;
            tx_s_q  <= tx_s_d;
            rx_m_q  <= rx_m_d;
            rx_s_q  <= rx_s_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            cnt_q   <= cnt_d;
            mosi_q  <= mosi_d;
            miso_q  <= miso_d;
            bist_q  <= bist_d;
        end
    end

    // Bit to present after the falling edge that completes bit cnt_q.
    assign nxt_bit = 3'd6 - cnt_q[2:0];

    // Fail bits are sticky; pass reflects the accumulated fail state.
    assign mosi_fail = bist_q[5] | (rx_s_q != tx_m_q);
    assign miso_fail = bist_q[4] | (rx_m_q != tx_s_q);
    assign xfer_cnt  = (bist_q[3:0] == 4'hF) ? 4'hF : bist_q[3:0] + 4'd1;

    always_comb begin
        state_d = state_q;
        tx_m_d  = tx_m_q;
        tx_s_d  = tx_s_q;
        rx_m_d  = rx_m_q;
        rx_s_d  = rx_s_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        cnt_d   = cnt_q;
        mosi_d  = mosi_q;
        miso_d  = miso_q;
        bist_d  = bist_q;

        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                if (bus.master_writeread) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_m_d    = bus.select ? bus.MOSI_user_input : DEF_MOSI;
                tx_s_d    = bus.select ? bus.MISO_user_input : DEF_MISO;
                cs_d      = 1'b0;
                sclk_d    = 1'b0;
                cnt_d     = 4'd0;
                mosi_d    = tx_m_d[7];
                miso_d    = tx_s_d[7];
                bist_d[7] = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    rx_s_d = {rx_s_q[6:0], mosi_q};
                    rx_m_d = {rx_m_q[6:0], miso_q};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        sclk_d  = 1'b0;
                        state_d = CHECK;
                    end else begin
                        mosi_d = tx_m_q[nxt_bit];
                        miso_d = tx_s_q[nxt_bit];
                    end
                end
            end
            CHECK: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                bist_d  = {1'b1, ~(mosi_fail | miso_fail), mosi_fail, miso_fail, xfer_cnt};
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.CS          = cs_q;
    assign bus.S_clk       = sclk_q;
    assign bus.counter     = cnt_q;
    assign bus.MOSI_res    = mosi_q;
    assign bus.MISO_res    = miso_q;
    assign bus.BIST_output = bist_q;

endmodule

// File: tb/tb_spi_bist.sv
// Self-checking bench for spi_bist: timeline reference model compared every cycle,
// directed literal scenarios, then randomized traffic with occasional resets.
module tb_spi_bist;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    bit   cmp_en;

    spi_bist_if bus ();

    spi_bist dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference model: p counts clock edges into a transfer
    // (0 idle, 1 in the load cycle, 2..18 = 0..16 shift edges done).
    int         p;
    logic [7:0] m_txm, m_txs;
    logic [3:0] m_lastcnt, m_n;
    logic       m_lastmosi, m_lastmiso, m_done, m_pass;

    always @(posedge clk) begin
        if (!reset) begin
            p = 0; m_lastcnt = 0; m_lastmosi = 0; m_lastmiso = 0;
            m_done = 0; m_pass = 0; m_n = 0; m_txm = 0; m_txs = 0;
        end else if (p == 0) begin
            if (bus.master_writeread) p = 1;
        end else if (p == 1) begin
            m_txm  = bus.select ? bus.MOSI_user_input : 8'hA5;
            m_txs  = bus.select ? bus.MISO_user_input : 8'h5A;
            m_done = 0;
            p = 2;
        end else if (p < 18) begin
            p++;
        end else begin
            // Ideal loopback: every received byte equals the byte sent.
            m_n        = (m_n == 4'd15) ? 4'd15 : m_n + 4'd1;
            m_done     = 1;
            m_pass     = 1;
            m_lastcnt  = 4'd8;
            m_lastmosi = m_txm[0];
            m_lastmiso = m_txs[0];
            p = 0;
        end
    end

    always @(negedge clk) begin
        logic       e_cs, e_sclk, e_mosi, e_miso;
        logic [3:0] e_cnt;
        int         j, k;
        if (cmp_en) begin
            if (p >= 2) begin
                j      = p - 2;
                k      = (j / 2 > 7) ? 7 : j / 2;
                e_cs   = 1'b0;
                e_sclk = j[0];
                e_cnt  = 4'(j / 2);
                e_mosi = m_txm[7 - k];
                e_miso = m_txs[7 - k];
            end else begin
                e_cs   = 1'b1;
                e_sclk = 1'b0;
                e_cnt  = m_lastcnt;
                e_mosi = m_lastmosi;
                e_miso = m_lastmiso;
            end
            chk("cycle_outputs",
                {16'h0, bus.CS, bus.S_clk, bus.MOSI_res, bus.MISO_res, bus.counter, bus.BIST_output},
                {16'h0, e_cs, e_sclk, e_mosi, e_miso, e_cnt, {m_done, m_pass, 2'b00, m_n}});
        end
    end

    // Observes one transfer: bits on S_clk rising samples, counter on falling samples.
    task automatic capture(input int chg_at, input logic [7:0] chg_val,
                           output logic [7:0] m, output logic [7:0] s, output int t0);
        int   t;
        int   nf;
        logic prev;
        m = 8'h00; s = 8'h00; t = 0; nf = 0; prev = 1'b0; t0 = cyc;
        while (bus.CS !== 1'b0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (bus.CS !== 1'b0) begin
            timeout_fail("cs_fall");
            return;
        end
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == chg_at) bus.MOSI_user_input = chg_val;
            if (bus.S_clk && !prev) begin
                m = {m[6:0], bus.MOSI_res};
                s = {s[6:0], bus.MISO_res};
            end
            if (!bus.S_clk && prev) begin
                nf++;
                chk("counter_step", 32'(bus.counter), 32'(nf));
            end
            prev = bus.S_clk;
        end
        t = 0;
        while (bus.CS !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (bus.CS !== 1'b1) timeout_fail("cs_rise");
    endtask

    initial begin
        logic [7:0] m, s;
        int         t0, t1, t;
        logic [3:0] n_before;

        checks = 0; errors = 0; cyc = 0; cmp_en = 0;
        reset = 1'b0;
        bus.master_writeread = 1'b1;
        bus.select           = 1'b1;
        bus.MOSI_user_input  = 8'h77;
        bus.MISO_user_input  = 8'h11;
        @(posedge clk);
        #1 cmp_en = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {bus.CS, bus.S_clk, bus.counter, bus.BIST_output}, {1'b1, 1'b0, 4'd0, 8'h00});

        bus.MOSI_user_input = 8'hF0;
        bus.MISO_user_input = 8'hF0;
        reset = 1'b1;
        capture(-1, 8'h00, m, s, t0);
        chk("first_mosi_stream", m, 8'hF0);
        chk("first_miso_stream", s, 8'hF0);
        chk("first_status", bus.BIST_output, 8'hC1);
        chk("first_cs_high", bus.CS, 1'b1);

        for (int i = 2; i <= 16; i++) begin
            capture(-1, 8'h00, m, s, t1);
            if (i == 2) chk("transfer_period", 32'(t1 - t0), 32'd19);
            chk("count_progress", bus.BIST_output, 8'hC0 | 8'((i > 15) ? 15 : i));
        end

        bus.select = 1'b0;
        capture(-1, 8'h00, m, s, t0);
        chk("default_mosi", m, 8'hA5);
        chk("default_miso", s, 8'h5A);
        chk("default_status", bus.BIST_output[6:4], 3'b100);

        bus.select = 1'b1;
        capture(5, 8'h3C, m, s, t0);
        chk("midchange_cur", m, 8'hF0);
        capture(-1, 8'h00, m, s, t0);
        chk("midchange_next_m", m, 8'h3C);
        chk("midchange_next_s", s, 8'hF0);
        chk("midchange_pass", bus.BIST_output[6:4], 3'b100);

        // Reset in the middle of a shift.
        t = 0;
        while (bus.CS !== 1'b0 && t < 60) begin @(negedge clk); t++; end
        if (bus.CS !== 1'b0) timeout_fail("cs_fall_rst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midshift_reset", {bus.CS, bus.S_clk, bus.counter, bus.BIST_output}, {1'b1, 1'b0, 4'd0, 8'h00});
        reset = 1'b1;

        // Drop the enable mid-transfer: exactly one more transfer completes.
        n_before = 4'd0;
        t = 0;
        while (bus.CS !== 1'b0 && t < 60) begin @(negedge clk); t++; end
        if (bus.CS !== 1'b0) timeout_fail("cs_fall_drop");
        repeat (4) @(negedge clk);
        bus.master_writeread = 1'b0;
        t = 0;
        while (bus.CS !== 1'b1 && t < 30) begin @(negedge clk); t++; end
        if (bus.CS !== 1'b1) timeout_fail("cs_rise_drop");
        chk("drop_status", bus.BIST_output, 8'hC0 | 8'(n_before + 4'd1));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("drop_idle", {bus.CS, bus.S_clk}, 2'b10);
        end
        chk("drop_count_held", bus.BIST_output[3:0], 4'd1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.master_writeread = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) bus.select = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.MOSI_user_input = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus.MISO_user_input = 8'($urandom);
            reset = ($urandom_range(0, 299) != 0);
        end
        reset = 1'b1;
        bus.master_writeread = 1'b0;
        repeat (25) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
